fp_normalize_left: RTL and testbench
====================================

Name: fp_normalize_left

Overview:
- Post-add normalizer for the single-precision adder datapath; it is the left-shift counterpart of the alignment right shifter.
- Takes the raw 25-bit adder sum (carry bit plus 24-bit mantissa with hidden bit) and the common exponent.
- Produces a normalized 24-bit mantissa, an adjusted exponent and status flags.
- Iterative design: one left shift per cycle, controlled by an FSM, with valid/ready handshakes on both sides.

Parameters:
MANT_W, 24, mantissa width including hidden bit; input sum is MANT_W+1 bits
EXP_W, 8, exponent width; EXP_MAX = 2^EXP_W-1 (255) is reserved for overflow/infinity

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept operand; high only in IDLE
in_mant  input  25  adder sum; bit 24 = carry-out, bit 23 = hidden-bit position
in_exp  input  8  common (larger) exponent from alignment stage
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_mant  output  24  normalized mantissa
out_exp  output  8  adjusted exponent
out_shift  output  5  number of left shifts performed (0..23)
out_zero  output  1  result is exact zero
out_ovf  output  1  exponent overflow; result forced to infinity
out_unf  output  1  result is denormal (exponent field 0)

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0 except in_ready, which is 1 because the state is IDLE.
  - Working registers cleared.
  - Any operation in progress is aborted; no result is emitted.
- States: IDLE, EVAL, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid&in_ready: capture in_mant into working mant (25b) and in_exp into working exp.
  - Clear the shift counter and go to EVAL.
  - in_valid while not in IDLE is ignored.
- EVAL: one decision per clock, in this priority order:
  1. mant==0: out_mant=0, out_exp=0, out_zero=1, go DONE.
  2. mant[24]=1 (carry): mant >> 1, LSB truncated. exp+1 computed in 9 bits.
     - If the result is >= 255: out_ovf=1, out_exp=255, out_mant=0.
     - Otherwise: out_exp=exp+1, out_mant=mant[24:1].
     - Go DONE.
  3. mant[23]=1: out_mant=mant[23:0], out_exp=exp, go DONE.
     - Special case: if exp==0 (denormal operands summed into the normal range), out_exp=1 instead.
  4. exp<=1: denormal. out_mant=mant[23:0], out_exp=0, out_unf=1, go DONE. No further shift.
  5. Otherwise: mant << 1, exp-1, shift counter+1, stay in EVAL.
- out_shift is loaded from the shift counter when DONE is entered.
- DONE:
  - All outputs are held stable while out_ready is low.
  - On out_valid&out_ready: go IDLE.
  - Flags and outputs keep their values until the next DONE entry.
- Latency from acceptance edge to out_valid high:
  - 2 cycles with no shift (normalized, carry, zero and immediate-denormal cases).
  - k+2 cycles with k left shifts. Maximum is 25 (k=23).
- Throughput: no overlap between operations; next accept is possible the cycle after the output handshake.
- Arithmetic:
  - Exponent decrement never wraps; rule 4 stops shifting at exp 1.
  - Exponent increment is checked in 9 bits.
  - Flags are mutually exclusive; exactly one or none is set per result.
- Simultaneous events:
  - out_ready is sampled only in DONE.
  - Reset overrides every other input.

Test Plan:
- Already normalized: in_mant=0x0800000, in_exp=0x80 -> out_mant=0x800000, out_exp=0x80, out_shift=0, no flags, out_valid 2 cycles after accept.
- Maximum shift: in_mant=0x0000001, in_exp=0x80 -> out_mant=0x800000, out_exp=0x69, out_shift=23, out_valid 25 cycles after accept.
- Carry:
  - in_mant=0x1800001, in_exp=0x7F -> out_mant=0xC00000, out_exp=0x80, out_shift=0.
  - Same mantissa with in_exp=0xFE -> out_ovf=1, out_exp=0xFF, out_mant=0.
- Zero and denormal:
  - in_mant=0, in_exp=0x55 -> out_zero=1, out_exp=0, out_mant=0.
  - in_mant=0x0000100, in_exp=0x05 -> out_mant=0x001000, out_exp=0, out_unf=1, out_shift=4, latency 6.
- Backpressure and reset:
  - Hold out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored. Result handshakes when out_ready rises; IDLE on the next cycle.
  - Assert rst_n low mid-EVAL (during the 23-shift case) -> outputs 0 and in_ready=1 immediately. No result is produced after release.

Source files
------------

// File: rtl/fp_normalize_left.sv
// Post-add normalizer: iteratively left-shifts the adder sum until the hidden
// bit is set, handling carry-out, zero, exponent overflow and denormal results.
module fp_normalize_left #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8,
  localparam int unsigned SH_W  = $clog2(MANT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [SH_W-1:0]   out_shift,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [EXP_W:0]   EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  logic [1:0]        r_state;
  logic [MANT_W:0]   r_mant;
  logic [EXP_W-1:0]  r_exp;
  logic [SH_W-1:0]   r_cnt;
  logic [MANT_W-1:0] r_out_mant;
  logic [EXP_W-1:0]  r_out_exp;
  logic [SH_W-1:0]   r_out_shift;
  logic              r_zero;
  logic              r_ovf;
  logic              r_unf;

  // Carry increment is evaluated one bit wider so 254+1 and 255+1 both saturate.
  logic [EXP_W:0]    w_exp_inc;
  assign w_exp_inc = {1'b0, r_exp} + {{EXP_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_cnt       <= '0;
      r_out_mant  <= '0;
      r_out_exp   <= '0;
      r_out_shift <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mant  <= in_mant;
            r_exp   <= in_exp;
            r_cnt   <= '0;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (r_mant == '0) begin
            r_out_mant  <= '0;
            r_out_exp   <= '0;
            r_out_shift <= r_cnt;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_mant[MANT_W]) begin
            r_out_shift <= r_cnt;
            r_zero      <= 1'b0;
            r_unf       <= 1'b0;
            if (w_exp_inc >= EXP_MAX) begin
              r_out_mant <= '0;
              r_out_exp  <= '1;
              r_ovf      <= 1'b1;
            end else begin
              r_out_mant <= r_mant[MANT_W:1];
              r_out_exp  <= w_exp_inc[EXP_W-1:0];
              r_ovf      <= 1'b0;
            end
            r_state <= S_DONE;
          end else if (r_mant[MANT_W-1]) begin
            // A zero exponent here means denormals summed into the normal range.
            r_out_mant  <= r_mant[MANT_W-1:0];
            r_out_exp   <= (r_exp == '0) ? EXP_ONE : r_exp;
            r_out_shift <= r_cnt;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_exp <= EXP_ONE) begin
            r_out_mant  <= r_mant[MANT_W-1:0];
            r_out_exp   <= '0;
            r_out_shift <= r_cnt;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_mant <= {r_mant[MANT_W-1:0], 1'b0};
            r_exp  <= r_exp - EXP_ONE;
            r_cnt  <= r_cnt + SH_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_mant  = r_out_mant;
  assign out_exp   = r_out_exp;
  assign out_shift = r_out_shift;
  assign out_zero  = r_zero;
  assign out_ovf   = r_ovf;
  assign out_unf   = r_unf;

endmodule

// File: tb/tb_fp_normalize_left.sv
// Scoreboard bench for fp_normalize_left: a leading-zero-count reference model
// predicts each result; a monitor compares whenever out_valid is presented.
module tb_fp_normalize_left;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_shift;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  fp_normalize_left #(.MANT_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_shift(out_shift),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic [4:0]  shift;
    bit          zero;
    bit          ovf;
    bit          unf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  bit   seen     = 0;
  bit   check_idle = 0;
  bit   hold_low = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Result predicted from the leading-zero count and the available exponent headroom.
  function automatic exp_t model(input logic [24:0] m, input logic [7:0] e, input int acc);
    exp_t r;
    int   lz;
    int   ei;
    r = '{mant: '0, exp: '0, shift: '0, zero: 0, ovf: 0, unf: 0, acc: acc};
    ei = int'(e);
    if (m == 25'd0) begin
      r.zero = 1;
    end else if (m[24]) begin
      if (ei + 1 >= 255) begin
        r.ovf = 1;
        r.exp = 8'hFF;
      end else begin
        r.mant = m[24:1];
        r.exp  = 8'(ei + 1);
      end
    end else begin
      lz = 0;
      while (lz < 24 && !m[23 - lz]) lz++;
      if (lz == 0) begin
        r.mant = m[23:0];
        r.exp  = (ei == 0) ? 8'd1 : e;
      end else if (ei <= 1) begin
        r.mant = m[23:0];
        r.unf  = 1;
      end else if (lz <= ei - 1) begin
        r.mant  = m[23:0] << lz;
        r.exp   = 8'(ei - lz);
        r.shift = 5'(lz);
      end else begin
        r.mant  = m[23:0] << (ei - 1);
        r.shift = 5'(ei - 1);
        r.unf   = 1;
      end
    end
    return r;
  endfunction

  task automatic issue(input logic [24:0] m, input logic [7:0] e);
    int budget;
    budget = 0;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      in_mant  = m;
      in_exp   = e;
      in_valid = 1'b1;
      q.push_back(model(m, e, edge_cnt + 1));
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (q.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (check_idle) begin
          check("idle_after_hs", {31'd0, in_ready}, 32'd1);
          check_idle = 0;
        end
        out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (out_valid) begin
          if (q.size() == 0) begin
            check("spurious_result", {31'd0, out_valid}, 32'd0);
          end else begin
            e = q[0];
            if (!seen) begin
              check("latency", edge_cnt - e.acc + 1, int'(e.shift) + 2);
              seen = 1;
            end
            check("mant",  {8'd0, out_mant},   {8'd0, e.mant});
            check("exp",   {24'd0, out_exp},   {24'd0, e.exp});
            check("shift", {27'd0, out_shift}, {27'd0, e.shift});
            check("flags", {29'd0, out_zero, out_ovf, out_unf}, {29'd0, e.zero, e.ovf, e.unf});
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            if (out_ready) begin
              void'(q.pop_front());
              seen = 0;
              check_idle = 1;
            end
          end
        end
      end
    end
  end

  initial begin : driver
    logic [24:0] m;
    int          wbits;
    int          budget;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {out_mant, out_exp} | {27'd0, out_shift, out_zero, out_ovf, out_unf}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(25'h0800000, 8'h80);
    issue(25'h0000001, 8'h80);
    issue(25'h1800001, 8'h7F);
    issue(25'h1800001, 8'hFE);
    issue(25'h1800001, 8'hFF);
    issue(25'h0000000, 8'h55);
    issue(25'h0000100, 8'h05);
    issue(25'h0800000, 8'h00);
    issue(25'h0400000, 8'h01);
    issue(25'h0400000, 8'h02);
    wait_drain();

    // Backpressure: hold out_ready low and poke in_valid while the result waits.
    hold_low = 1;
    @(negedge clk);
    issue(25'h0000003, 8'h40);
    budget = 0;
    while (!out_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("bp_reached_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_mant  = 25'($urandom);
      in_exp   = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold_low = 0;
    wait_drain();

    // Reset during a long shift sequence must abort without a result.
    issue(25'h0000001, 8'h80);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    seen = 0;
    check_idle = 0;
    #1;
    check("abort_in_ready",  {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_outputs", {out_mant, out_exp} | {27'd0, out_shift, out_zero, out_ovf, out_unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_result", {31'd0, out_valid}, 32'd0);

    for (int n = 0; n < 80; n++) begin
      wbits = $urandom_range(0, 25);
      m = 25'($urandom) & ((25'd1 << wbits) - 25'd1);
      issue(m, 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
